// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic {HZ_IDLE, HZ_VMEM} hz_state_t;
  function automatic int lanes(input int v, input int n);
    return v / n;
  endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: one execute operand's forward-source select; memory stage wins over writeback.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0] tag,
  input  logic [M-1:0] m_tag,
  input  logic         m_wen,
  input  logic [M-1:0] w_tag,
  input  logic         w_wen,
  output fwd_sel_t     sel
);
  always_comb sel = (m_wen && m_tag == tag) ? FWD_MEM : (w_wen && w_tag == tag) ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for load-use, taken branch and multi-beat vector loads.
// Define HAZARD_FWD_EN to enable operand forwarding from M/W instead of stalling on E/M producers.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] regAD,
  input  logic [M-1:0] regBD,
  input  logic         useA_D,
  input  logic         useB_D,
  input  logic [M-1:0] regAE,
  input  logic [M-1:0] regBE,
  input  logic [M-1:0] regScr_E,
  input  logic         regw_E,
  input  logic         regmem_E,
  input  logic         vect_E,
  input  logic         branch_E,
  input  logic         brtaken_E,
  input  logic [M-1:0] regScr_M,
  input  logic         regw_M,
  input  logic [M-1:0] regScr_W,
  input  logic         regw_W,
  output logic         stall_F,
  output logic         stall_D,
  output logic         stall_E,
  output logic         flush_D,
  output logic         flush_E,
  output logic [1:0]   fwdA_E,
  output logic [1:0]   fwdB_E
);
  localparam int LANES = lanes(V, N);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  hz_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic br, vld, hit_ea, hit_eb, hz;
  assign br = branch_E & brtaken_E;
  assign vld = vect_E & regmem_E & (LANES > 1);
  assign hit_ea = useA_D & (regAD == regScr_E);
  assign hit_eb = useB_D & (regBD == regScr_E);
`ifdef HAZARD_FWD_EN
  fwd_sel_t fa, fb;
  assign hz = regmem_E & regw_E & (hit_ea | hit_eb);
  hazard_fwd_sel #(.M(M)) u_fwd_a (.tag(regAE), .m_tag(regScr_M), .m_wen(regw_M), .w_tag(regScr_W), .w_wen(regw_W), .sel(fa));
  hazard_fwd_sel #(.M(M)) u_fwd_b (.tag(regBE), .m_tag(regScr_M), .m_wen(regw_M), .w_tag(regScr_W), .w_wen(regw_W), .sel(fb));
  assign fwdA_E = rst ? FWD_NONE : fa;
  assign fwdB_E = rst ? FWD_NONE : fb;
`else
  logic hit_ma, hit_mb, unused_fwd;
  assign hit_ma = useA_D & (regAD == regScr_M);
  assign hit_mb = useB_D & (regBD == regScr_M);
  // Without forwarding any in-flight E/M producer stalls; W is covered by the write-first register file.
  assign hz = (regw_E & (hit_ea | hit_eb)) | (regw_M & (hit_ma | hit_mb));
  assign unused_fwd = ^{regAE, regBE, regScr_W, regw_W};
  assign fwdA_E = FWD_NONE;
  assign fwdB_E = FWD_NONE;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // The detecting cycle is the first stall beat, so HZ_VMEM covers the remaining LANES-2 beats.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    {stall_F, stall_D, stall_E, flush_D, flush_E} = '0;
    if (state == HZ_VMEM) begin
      {stall_F, stall_D, stall_E} = '1;
      cnt_n = cnt - 1'b1;
      state_n = (cnt_n == '0) ? HZ_IDLE : HZ_VMEM;
    end else if (br) begin
      {flush_D, flush_E} = '1;
    end else if (vld) begin
      {stall_F, stall_D, stall_E} = '1;
      if (LANES > 2) begin
        state_n = HZ_VMEM;
        cnt_n = CW'(LANES - 2);
      end
    end else if (hz) begin
      {stall_F, stall_D, flush_E} = '1;
    end
    if (rst) {stall_F, stall_D, stall_E, flush_D, flush_E} = '0;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (default V=128, N=32, M=4).
module tb_hazard_ctrl;
  import hazard_pkg::*;
  localparam int M = 4;
  localparam logic [8:0] NO = 9'b000000000, LU = 9'b110010000, BR = 9'b000110000, VS = 9'b111000000;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [M-1:0] regAD, regBD, regAE, regBE, regScr_E, regScr_M, regScr_W;
  logic useA_D, useB_D, regw_E, regmem_E, vect_E, branch_E, brtaken_E, regw_M, regw_W;
  logic stall_F, stall_D, stall_E, flush_D, flush_E;
  logic [1:0] fwdA_E, fwdB_E;
  logic [8:0] outs;
  logic [8:0] sb[$];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .regAD(regAD), .regBD(regBD), .useA_D(useA_D), .useB_D(useB_D),
    .regAE(regAE), .regBE(regBE), .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E),
    .vect_E(vect_E), .branch_E(branch_E), .brtaken_E(brtaken_E), .regScr_M(regScr_M),
    .regw_M(regw_M), .regScr_W(regScr_W), .regw_W(regw_W), .stall_F(stall_F), .stall_D(stall_D),
    .stall_E(stall_E), .flush_D(flush_D), .flush_E(flush_E), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E)
  );
  assign outs = {stall_F, stall_D, stall_E, flush_D, flush_E, fwdA_E, fwdB_E};

  task automatic clear_inputs();
    {regAD, regBD, regAE, regBE, regScr_E, regScr_M, regScr_W} = '0;
    {useA_D, useB_D, regw_E, regmem_E, vect_E, branch_E, brtaken_E, regw_M, regw_W} = '0;
  endtask

  function automatic logic [8:0] model();
    logic ea, eb, ma, mb, hz;
    logic [1:0] fa, fb;
    ea = useA_D && regAD == regScr_E;
    eb = useB_D && regBD == regScr_E;
    ma = useA_D && regAD == regScr_M;
    mb = useB_D && regBD == regScr_M;
    hz = FWD ? (regmem_E && regw_E && (ea || eb)) : ((regw_E && (ea || eb)) || (regw_M && (ma || mb)));
    fa = !FWD ? 2'b00 : (regw_M && regScr_M == regAE) ? 2'b10 : (regw_W && regScr_W == regAE) ? 2'b01 : 2'b00;
    fb = !FWD ? 2'b00 : (regw_M && regScr_M == regBE) ? 2'b10 : (regw_W && regScr_W == regBE) ? 2'b01 : 2'b00;
    return (branch_E && brtaken_E) ? {5'b00011, fa, fb} : hz ? {5'b11001, fa, fb} : {5'b00000, fa, fb};
  endfunction

  task automatic test_reset();
    logic [8:0] e;
    clear_inputs();
    rst = 1'b1;
    {branch_E, brtaken_E, vect_E, regmem_E, regw_E, useA_D, regw_M, regw_W} = '1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(NO);
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL reset cycle %0d got %b want %b", i, outs, e); end
      @(negedge clk);
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      if (i == 0) {regmem_E, regw_E, regScr_E, regAD, useA_D} = {1'b1, 1'b1, 4'd3, 4'd3, 1'b1};
      sb.push_back(i == 0 ? LU : NO);
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL load_use cycle %0d got %b want %b", i, outs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [8:0] e;
    clear_inputs();
    {regmem_E, regw_E, regScr_E, regAD, useA_D, branch_E, brtaken_E} = {1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1};
    sb.push_back(BR);
    #2 e = sb.pop_front();
    checks++;
    if (outs !== e) begin fails++; $display("FAIL branch got %b want %b", outs, e); end
    @(negedge clk);
    brtaken_E = 1'b0;
    sb.push_back(LU);
    #2 e = sb.pop_front();
    checks++;
    if (outs !== e) begin fails++; $display("FAIL branch_not_taken got %b want %b", outs, e); end
    @(negedge clk);
  endtask

  task automatic test_vector(input string nm, input int rst_at);
    logic [8:0] e;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      rst = (i == rst_at);
      if (i < 3 && !(rst_at >= 0 && i > rst_at)) {vect_E, regmem_E, regw_E, regScr_E} = {1'b1, 1'b1, 1'b1, 4'd9};
      if (i == 1 || i == 3) {branch_E, brtaken_E} = 2'b11;
      if (rst_at >= 0) e = (i == 0) ? VS : (i == 3) ? BR : NO;
      else e = (i < 3) ? VS : (i == 3) ? BR : NO;
      sb.push_back(e);
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL %s cycle %0d got %b want %b", nm, i, outs, e); end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_fwd();
    logic [8:0] e;
    clear_inputs();
    {regw_M, regScr_M, regw_W, regScr_W, regAE, regBE} = {1'b1, 4'd5, 1'b1, 4'd5, 4'd5, 4'd7};
    for (int i = 0; i < 3; i++) begin
      if (i == 1) regw_M = 1'b0;
      if (i == 2) {regw_M, regBE} = {1'b1, 4'd5};
      e = {5'b0, FWD ? (i == 1 ? 2'b01 : 2'b10) : 2'b00, (FWD && i == 2) ? 2'b10 : 2'b00};
      sb.push_back(e);
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL fwd case %0d got %b want %b", i, outs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_no_fwd();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      if (i == 0) {regw_E, regScr_E, regBD, useB_D} = {1'b1, 4'd2, 4'd2, 1'b1};
      if (i == 1) {regw_M, regScr_M, regAD, useA_D} = {1'b1, 4'd4, 4'd4, 1'b1};
      if (i == 2) {regw_W, regScr_W, regAD, useA_D} = {1'b1, 4'd6, 4'd6, 1'b1};
      if (i == 3) {regw_E, regScr_E, regBD, useB_D} = {1'b1, 4'd2, 4'd2, 1'b0};
      sb.push_back((i < 2 && !FWD) ? LU : NO);
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL no_fwd case %0d got %b want %b", i, outs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 60; i++) begin
      {regAD, regBD, regAE, regBE} = {4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))};
      {regScr_E, regScr_M, regScr_W} = {4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))};
      {useA_D, useB_D, regw_E, regmem_E, regw_M, regw_W} = 6'($urandom);
      branch_E = ($urandom_range(3) == 0);
      brtaken_E = 1'($urandom);
      vect_E = 1'b0;
      sb.push_back(model());
      #2 e = sb.pop_front();
      checks++;
      if (outs !== e) begin fails++; $display("FAIL random cycle %0d got %b want %b", i, outs, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_vector("vector", -1);
    test_fwd();
    test_no_fwd();
    test_vector("vmem_reset", 1);
    test_vector("vector_after_reset", -1);
    test_random();
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard leftover got %0d want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
